// File: rtl/regfile_wb_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_ctrl_pkg
// Description : Shared core constants and types for the register-file
//               writeback controller.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_wb_ctrl_pkg;

    localparam int c_xlen            = 32;
    localparam int c_reg_aw          = 5;
    localparam int c_num_regs        = 1 << c_reg_aw;
    localparam int c_mdu_fifo_depth  = 2;

    typedef struct packed {
        logic [c_reg_aw-1:0] rd;
        logic [c_xlen-1:0]   data;
    } wb_entry_t;

    // x0 is hardwired, so it never appears in any busy/clear mask.
    function automatic logic [c_num_regs-1:0] reg_onehot(input logic [c_reg_aw-1:0] rd);
        reg_onehot     = '0;
        reg_onehot[rd] = (rd != '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wb_ctrl_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Small FIFO buffering multiply/divide results awaiting a free
//               register-file write slot.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
    import regfile_wb_ctrl_pkg::*;
#(
    parameter  int DEPTH = c_mdu_fifo_depth,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  wb_entry_t  i_push_data,
    input  logic       i_pop,
    output wb_entry_t  o_head,
    output logic       o_full,
    output logic       o_empty,
    output logic [AW:0] o_count
);

    wb_entry_t     r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_ctrl
// Description : Register-file write port arbiter between the pipeline
//               writeback and buffered multiply/divide results, plus the
//               multiply/divide destination scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_ctrl
    import regfile_wb_ctrl_pkg::*;
#(
    parameter int DEPTH = c_mdu_fifo_depth
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_valid,
    input  logic [c_reg_aw-1:0]   wb_rd,
    input  logic [c_xlen-1:0]     wb_data,
    input  logic                  mdu_valid,
    input  logic [c_reg_aw-1:0]   mdu_rd,
    input  logic [c_xlen-1:0]     mdu_data,
    output logic                  mdu_ready,
    input  logic                  issue_valid,
    input  logic [c_reg_aw-1:0]   issue_rd,
    output logic [c_num_regs-1:0] busy,
    output logic                  stall_req,
    output logic                  regwrite,
    output logic [c_reg_aw-1:0]   writereg_addr,
    output logic [c_xlen-1:0]     writedata
);

    localparam int c_aw = $clog2(DEPTH);

    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [c_aw:0]         w_fifo_count;
    wb_entry_t             w_fifo_head;
    wb_entry_t             w_mdu_entry;
    logic                  w_mdu_keep;
    logic                  w_pop;
    logic                  w_bypass;
    logic                  w_push;
    logic                  w_sel_we;
    logic                  w_sel_mdu;
    logic [c_reg_aw-1:0]   w_sel_rd;
    logic [c_xlen-1:0]     w_sel_data;
    logic [c_num_regs-1:0] w_busy_set;
    logic [c_num_regs-1:0] w_busy_clr;

    logic                  r_regwrite;
    logic [c_reg_aw-1:0]   r_writereg_addr;
    logic [c_xlen-1:0]     r_writedata;
    logic [c_num_regs-1:0] r_busy;

    assign mdu_ready   = !w_fifo_full;
    assign stall_req   = (w_fifo_count >= (c_aw+1)'(DEPTH-1));
    assign w_mdu_entry = '{rd: mdu_rd, data: mdu_data};

    // rd==0 results are consumed by the handshake but go nowhere.
    assign w_mdu_keep = mdu_valid && mdu_ready && (mdu_rd != '0);
    assign w_pop      = !wb_valid && !w_fifo_empty;
    assign w_bypass   = !wb_valid && w_fifo_empty && w_mdu_keep;
    assign w_push     = w_mdu_keep && !w_bypass;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_wb_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_mdu_entry),
        .i_pop       (w_pop),
        .o_head      (w_fifo_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    always_comb begin
        w_sel_we   = 1'b0;
        w_sel_mdu  = 1'b0;
        w_sel_rd   = '0;
        w_sel_data = '0;
        if (wb_valid) begin
            w_sel_we   = (wb_rd != '0);
            w_sel_rd   = wb_rd;
            w_sel_data = wb_data;
        end else if (w_pop) begin
            w_sel_we   = 1'b1;
            w_sel_mdu  = 1'b1;
            w_sel_rd   = w_fifo_head.rd;
            w_sel_data = w_fifo_head.data;
        end else if (w_bypass) begin
            w_sel_we   = 1'b1;
            w_sel_mdu  = 1'b1;
            w_sel_rd   = mdu_rd;
            w_sel_data = mdu_data;
        end
    end

    assign w_busy_set = issue_valid ? reg_onehot(issue_rd) : '0;
    assign w_busy_clr = w_sel_mdu   ? reg_onehot(w_sel_rd) : '0;

    // Busy clears on the same edge that launches the write onto regwrite;
    // a simultaneous issue to the same rd wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_regwrite      <= 1'b0;
            r_writereg_addr <= '0;
            r_writedata     <= '0;
            r_busy          <= '0;
        end else begin
            r_regwrite      <= w_sel_we;
            r_writereg_addr <= w_sel_rd;
            r_writedata     <= w_sel_data;
            r_busy          <= (r_busy & ~w_busy_clr) | w_busy_set;
        end
    end

    assign regwrite      = r_regwrite;
    assign writereg_addr = r_writereg_addr;
    assign writedata     = r_writedata;
    assign busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_ctrl
// Description : Directed vector bench for regfile_wb_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_ctrl;

    typedef struct {
        logic        wb_valid;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        mdu_valid;
        logic [4:0]  mdu_rd;
        logic [31:0] mdu_data;
        logic        issue_valid;
        logic [4:0]  issue_rd;
        logic        exp_we;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        logic [31:0] exp_busy;
        logic        exp_ready;
        logic        exp_stall;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        mdu_valid = 1'b0;
    logic [4:0]  mdu_rd = '0;
    logic [31:0] mdu_data = '0;
    logic        mdu_ready;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic [31:0] busy;
    logic        stall_req;
    logic        regwrite;
    logic [4:0]  writereg_addr;
    logic [31:0] writedata;

    int n_pass  = 0;
    int n_total = 0;
    vec_t vecs[$];

    regfile_wb_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .mdu_valid     (mdu_valid),
        .mdu_rd        (mdu_rd),
        .mdu_data      (mdu_data),
        .mdu_ready     (mdu_ready),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .busy          (busy),
        .stall_req     (stall_req),
        .regwrite      (regwrite),
        .writereg_addr (writereg_addr),
        .writedata     (writedata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                                input logic mv, input logic [4:0] mr, input logic [31:0] md,
                                input logic iv, input logic [4:0] ir,
                                input logic ewe, input logic [4:0] ea, input logic [31:0] ed,
                                input logic [31:0] eb, input logic erdy, input logic estl);
        vec_t v;
        v = '{wv, wr, wd, mv, mr, md, iv, ir, ewe, ea, ed, eb, erdy, estl};
        return v;
    endfunction

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic apply(input vec_t v);
        wb_valid    = v.wb_valid;
        wb_rd       = v.wb_rd;
        wb_data     = v.wb_data;
        mdu_valid   = v.mdu_valid;
        mdu_rd      = v.mdu_rd;
        mdu_data    = v.mdu_data;
        issue_valid = v.issue_valid;
        issue_rd    = v.issue_rd;
        @(posedge clk);
        #1;
    endtask

    task automatic compare(input string tag, input vec_t v);
        check({tag, " regwrite"}, {31'd0, regwrite}, {31'd0, v.exp_we});
        if (v.exp_we) begin
            check({tag, " addr"}, {27'd0, writereg_addr}, {27'd0, v.exp_addr});
            check({tag, " data"}, writedata, v.exp_data);
        end
        check({tag, " busy"}, busy, v.exp_busy);
        check({tag, " mdu_ready"}, {31'd0, mdu_ready}, {31'd0, v.exp_ready});
        check({tag, " stall_req"}, {31'd0, stall_req}, {31'd0, v.exp_stall});
    endtask

    vec_t idle;

    initial begin
        idle = mk(0,0,0, 0,0,0, 0,0, 0,0,0, 32'h0, 1, 0);
        //          wb            mdu              issue   exp we/addr/data          busy          rdy stl
        vecs.push_back(mk(0,0,0,            0,0,0,          0,0,  0,0,0,                32'h0,        1, 0));
        vecs.push_back(mk(1,5,32'hDEADBEEF, 0,0,0,          0,0,  1,5,32'hDEADBEEF,     32'h0,        1, 0));
        vecs.push_back(mk(0,0,0,            0,0,0,          0,0,  0,0,0,                32'h0,        1, 0));
        vecs.push_back(mk(0,0,0,            0,0,0,          1,7,  0,0,0,                32'h80,       1, 0));
        vecs.push_back(mk(0,0,0,            1,7,32'h12,     0,0,  1,7,32'h12,           32'h0,        1, 0));
        vecs.push_back(mk(1,0,32'h1,        0,0,0,          1,3,  0,0,0,                32'h8,        1, 0));
        vecs.push_back(mk(0,0,0,            1,0,32'h55,     0,0,  0,0,0,                32'h8,        1, 0));
        vecs.push_back(mk(0,0,0,            0,0,0,          1,9,  0,0,0,                32'h208,      1, 0));
        vecs.push_back(mk(0,0,0,            1,9,32'h99,     1,9,  1,9,32'h99,           32'h208,      1, 0));
        vecs.push_back(mk(0,0,0,            1,3,32'h33,     0,0,  1,3,32'h33,           32'h200,      1, 0));
        vecs.push_back(mk(1,1,32'h1111,     1,10,32'hA0,    0,0,  1,1,32'h1111,         32'h200,      1, 1));
        vecs.push_back(mk(1,2,32'h2222,     1,11,32'hB0,    0,0,  1,2,32'h2222,         32'h200,      0, 1));
        vecs.push_back(mk(1,4,32'h4444,     1,12,32'hC0,    0,0,  1,4,32'h4444,         32'h200,      0, 1));
        vecs.push_back(mk(0,0,0,            0,0,0,          0,0,  1,10,32'hA0,          32'h200,      1, 1));
        vecs.push_back(mk(0,0,0,            1,13,32'hD0,    0,0,  1,11,32'hB0,          32'h200,      1, 1));
        vecs.push_back(mk(0,0,0,            0,0,0,          0,0,  1,13,32'hD0,          32'h200,      1, 0));
        vecs.push_back(mk(0,0,0,            0,0,0,          0,0,  0,0,0,                32'h200,      1, 0));

        // State while held in reset.
        #12;
        check("reset regwrite",  {31'd0, regwrite},  32'd0);
        check("reset busy",      busy,               32'd0);
        check("reset mdu_ready", {31'd0, mdu_ready}, 32'd1);
        check("reset stall_req", {31'd0, stall_req}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            compare($sformatf("v%0d", i), vecs[i]);
        end

        // Asynchronous reset while one result sits in the FIFO.
        apply(mk(0,0,0, 0,0,0, 1,20, 0,0,0, 32'h0, 1, 0));
        check("pre-rst busy", busy, 32'h0010_0200);
        apply(mk(1,6,32'h66, 1,20,32'hEE, 0,0, 0,0,0, 32'h0, 1, 0));
        check("pre-rst stall_req", {31'd0, stall_req}, 32'd1);
        check("pre-rst writedata", writedata, 32'h66);
        wb_valid = 1'b0; mdu_valid = 1'b0; issue_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("async rst busy",      busy,               32'd0);
        check("async rst regwrite",  {31'd0, regwrite},  32'd0);
        check("async rst mdu_ready", {31'd0, mdu_ready}, 32'd1);
        check("async rst stall_req", {31'd0, stall_req}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            apply(idle);
            compare($sformatf("post-rst%0d", i), idle);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
